// File: rtl/rsa_cipher_unpacker.sv
`default_nettype none
// ============================================================================
// rsa_cipher_unpacker - packs ciphertext bytes into a word for the exp-mod
// engine, range-checks the result and streams the plaintext out MSB first.
// Optional watchdog: define RSA_UNPACK_WATCHDOG_EN.        Revision: 1.0
// ============================================================================
module rsa_cipher_unpacker #(
  parameter int MSG_BYTES      = 2,
  parameter int KEY_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid_in,
  output logic                   byte_ready_out,
  output logic                   engine_ready_out,
  output logic [8*KEY_BYTES-1:0] engine_value_out,
  input  logic                   engine_busy_in,
  input  logic                   engine_valid_in,
  input  logic [8*KEY_BYTES-1:0] engine_result_in,
  output logic [7:0]             byte_out,
  output logic                   byte_valid_out,
  input  logic                   byte_ready_in,
  output logic                   busy_out,
  output logic                   error_out,
  output logic [15:0]            block_count_out
);

  localparam int c_MSG_WIDTH = 8 * MSG_BYTES;
  localparam int c_KEY_WIDTH = 8 * KEY_BYTES;
  localparam int c_CNT_W     = $clog2(KEY_BYTES) + 1;

  localparam logic [1:0] c_COLLECT = 2'd0;
  localparam logic [1:0] c_ISSUE   = 2'd1;
  localparam logic [1:0] c_WAIT    = 2'd2;
  localparam logic [1:0] c_EMIT    = 2'd3;

  logic [1:0]             r_state;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_KEY_WIDTH-1:0] r_shift;
  logic [c_KEY_WIDTH-1:0] r_value;
  logic [c_MSG_WIDTH-1:0] r_msg;
  logic                   r_error;
  logic [15:0]            r_blocks;
  logic [c_KEY_WIDTH-1:0] w_shift_next;
  logic                   w_overflow;

`ifdef RSA_UNPACK_WATCHDOG_EN
  localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_WD_W-1:0] r_wd;
`else
  logic [1:0] w_unused;
  assign w_unused = {engine_busy_in, (TIMEOUT_CYCLES > 0)};
`endif

  assign w_shift_next = (r_shift << 8) | c_KEY_WIDTH'(byte_in);
  assign w_overflow   = |(engine_result_in >> c_MSG_WIDTH);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= c_COLLECT;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_value  <= '0;
      r_msg    <= '0;
      r_error  <= 1'b0;
      r_blocks <= '0;
`ifdef RSA_UNPACK_WATCHDOG_EN
      r_wd     <= '0;
`endif
    end else begin
      r_error <= 1'b0;
      case (r_state)
        c_COLLECT: begin
          if (byte_valid_in) begin
            r_shift <= w_shift_next;
            if (r_cnt == c_CNT_W'(KEY_BYTES - 1)) begin
              r_cnt   <= '0;
              r_value <= w_shift_next;
              r_state <= c_ISSUE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        c_ISSUE: begin
          r_state <= c_WAIT;
`ifdef RSA_UNPACK_WATCHDOG_EN
          r_wd    <= '0;
`endif
        end
        c_WAIT: begin
          // A result strobe takes priority over watchdog expiry on the same cycle.
          if (engine_valid_in) begin
            if (w_overflow) begin
              r_error <= 1'b1;
              r_state <= c_COLLECT;
            end else begin
              r_msg   <= engine_result_in[c_MSG_WIDTH-1:0];
              r_cnt   <= '0;
              r_state <= c_EMIT;
            end
          end
`ifdef RSA_UNPACK_WATCHDOG_EN
          else if (r_wd == c_WD_W'(TIMEOUT_CYCLES - 1)) begin
            r_error <= 1'b1;
            r_state <= c_COLLECT;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
`endif
        end
        c_EMIT: begin
          if (byte_ready_in) begin
            r_msg <= r_msg << 8;
            if (r_cnt == c_CNT_W'(MSG_BYTES - 1)) begin
              r_cnt    <= '0;
              r_blocks <= r_blocks + 16'd1;
              r_state  <= c_COLLECT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= c_COLLECT;
      endcase
    end
  end

  assign byte_ready_out   = (r_state == c_COLLECT) && !rst_in;
  assign engine_ready_out = (r_state == c_ISSUE) && !rst_in;
  assign byte_valid_out   = (r_state == c_EMIT) && !rst_in;
  assign busy_out         = (r_state != c_COLLECT) && !rst_in;
  assign engine_value_out = r_value;
  assign byte_out         = r_msg[c_MSG_WIDTH-1 -: 8];
  assign error_out        = r_error;
  assign block_count_out  = r_blocks;

endmodule
`default_nettype wire

// File: tb/tb_rsa_cipher_unpacker.sv
`default_nettype none
// Testbench for rsa_cipher_unpacker: directed blocks with a byte/word scoreboard.
module tb_rsa_cipher_unpacker;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  byte_in;
  logic        byte_valid_in;
  logic        byte_ready_out;
  logic        engine_ready_out;
  logic [31:0] engine_value_out;
  logic        engine_busy_in;
  logic        engine_valid_in;
  logic [31:0] engine_result_in;
  logic [7:0]  byte_out;
  logic        byte_valid_out;
  logic        byte_ready_in;
  logic        busy_out;
  logic        error_out;
  logic [15:0] block_count_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_words[$];
  logic [7:0]  exp_bytes[$];

  always #5 clk_in = ~clk_in;

  rsa_cipher_unpacker #(
    .MSG_BYTES(2), .KEY_BYTES(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .byte_in(byte_in), .byte_valid_in(byte_valid_in), .byte_ready_out(byte_ready_out),
    .engine_ready_out(engine_ready_out), .engine_value_out(engine_value_out),
    .engine_busy_in(engine_busy_in), .engine_valid_in(engine_valid_in),
    .engine_result_in(engine_result_in),
    .byte_out(byte_out), .byte_valid_out(byte_valid_out), .byte_ready_in(byte_ready_in),
    .busy_out(busy_out), .error_out(error_out), .block_count_out(block_count_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 20 && !byte_ready_out; k++) tick();
    chk("byte_ready_wait", {31'd0, byte_ready_out}, 32'd1);
    byte_in = b;
    byte_valid_in = 1'b1;
    tick();
    byte_valid_in = 1'b0;
  endtask

  // Leaves the bench in the ISSUE cycle, after checking the engine request.
  task automatic send_word(input logic [31:0] w, input bit gaps);
    exp_words.push_back(w);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        byte_in = 8'hFF;
        byte_valid_in = 1'b0;
        tick();
      end
      send_byte(w[31-8*i -: 8]);
    end
    chk("issue_ready", {31'd0, engine_ready_out}, 32'd1);
    chk("issue_value", engine_value_out, exp_words.pop_front());
    chk("issue_busy", {31'd0, busy_out}, 32'd1);
  endtask

  task automatic respond(input logic [31:0] res, input int delay);
    for (int k = 0; k < delay; k++) tick();
    if (res[31:16] == 16'd0) begin
      exp_bytes.push_back(res[15:8]);
      exp_bytes.push_back(res[7:0]);
    end
    engine_valid_in  = 1'b1;
    engine_result_in = res;
    tick();
    engine_valid_in  = 1'b0;
    engine_result_in = 32'h0;
  endtask

  task automatic recv_block(input int stall, input logic [15:0] exp_count);
    int first = 1;
    for (int k = 0; k < 50 && exp_bytes.size() != 0; k++) begin
      if (first == 1 && stall > 0) begin
        byte_ready_in = 1'b0;
        chk("stall_valid", {31'd0, byte_valid_out}, 32'd1);
        chk("stall_hold", {24'd0, byte_out}, {24'd0, exp_bytes[0]});
        stall--;
      end else begin
        byte_ready_in = 1'b1;
        first = 0;
        if (byte_valid_out) chk("emit_byte", {24'd0, byte_out}, {24'd0, exp_bytes.pop_front()});
      end
      tick();
    end
    byte_ready_in = 1'b0;
    chk("emit_done", exp_bytes.size(), 32'd0);
    chk("post_busy", {31'd0, busy_out}, 32'd0);
    chk("post_valid", {31'd0, byte_valid_out}, 32'd0);
    chk("post_count", {16'd0, block_count_out}, {16'd0, exp_count});
  endtask

  task automatic check_reset_outputs();
    chk("rst_byte_ready", {31'd0, byte_ready_out}, 32'd0);
    chk("rst_eng_ready", {31'd0, engine_ready_out}, 32'd0);
    chk("rst_eng_value", engine_value_out, 32'd0);
    chk("rst_byte_out", {24'd0, byte_out}, 32'd0);
    chk("rst_byte_valid", {31'd0, byte_valid_out}, 32'd0);
    chk("rst_busy", {31'd0, busy_out}, 32'd0);
    chk("rst_error", {31'd0, error_out}, 32'd0);
    chk("rst_count", {16'd0, block_count_out}, 32'd0);
  endtask

  initial begin
    rst_in = 1'b1;
    byte_in = 8'h00;
    byte_valid_in = 1'b0;
    engine_busy_in = 1'b0;
    engine_valid_in = 1'b0;
    engine_result_in = 32'h0;
    byte_ready_in = 1'b0;
    tick();
    tick();
    check_reset_outputs();
    rst_in = 1'b0;
    #1;
    chk("idle_ready", {31'd0, byte_ready_out}, 32'd1);

    // Normal block
    send_word(32'h0000_1234, 1'b0);
    tick();
    chk("issue_one_cycle", {31'd0, engine_ready_out}, 32'd0);
    chk("value_stable", engine_value_out, 32'h0000_1234);
    respond(32'h0000_BEEF, 4);
    chk("first_valid_latency", {31'd0, byte_valid_out}, 32'd1);
    chk("no_input_in_emit", {31'd0, byte_ready_out}, 32'd0);
    recv_block(0, 16'd1);

    // Overflowing result
    send_word(32'hCAFE_0102, 1'b0);
    respond(32'h0001_BEEF, 3);
    chk("ovf_error", {31'd0, error_out}, 32'd1);
    chk("ovf_no_valid", {31'd0, byte_valid_out}, 32'd0);
    chk("ovf_ready", {31'd0, byte_ready_out}, 32'd1);
    chk("ovf_count", {16'd0, block_count_out}, 32'd1);
    tick();
    chk("ovf_error_pulse", {31'd0, error_out}, 32'd0);

    // Input gaps and output backpressure
    send_word(32'h1122_3344, 1'b1);
    respond(32'h0000_BEEF, 2);
    recv_block(3, 16'd2);

    // Reset during WAIT, then a stale engine result
    send_word(32'h5566_7788, 1'b0);
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    check_reset_outputs();
    rst_in = 1'b0;
    tick();
    engine_valid_in  = 1'b1;
    engine_result_in = 32'h0000_AAAA;
    tick();
    engine_valid_in  = 1'b0;
    tick();
    chk("stale_no_valid", {31'd0, byte_valid_out}, 32'd0);
    chk("stale_no_error", {31'd0, error_out}, 32'd0);
    chk("stale_ready", {31'd0, byte_ready_out}, 32'd1);
    send_word(32'h0BAD_F00D, 1'b0);
    respond(32'h0000_1357, 1);
    recv_block(0, 16'd1);

    // Spurious engine strobe mid-collection
    send_byte(8'hDE);
    send_byte(8'hAD);
    engine_valid_in  = 1'b1;
    engine_result_in = 32'h0000_FFFF;
    tick();
    engine_valid_in  = 1'b0;
    chk("spur_no_error", {31'd0, error_out}, 32'd0);
    chk("spur_no_valid", {31'd0, byte_valid_out}, 32'd0);
    exp_words.push_back(32'hDEAD_BEEF);
    send_byte(8'hBE);
    send_byte(8'hEF);
    chk("spur_issue", {31'd0, engine_ready_out}, 32'd1);
    chk("spur_value", engine_value_out, exp_words.pop_front());
    respond(32'h0000_0042, 2);
    recv_block(0, 16'd2);

    // Engine never answers
    send_word(32'h0102_0304, 1'b0);
    for (int k = 0; k < 16; k++) tick();
    chk("wd_busy_early", {31'd0, busy_out}, 32'd1);
    chk("wd_no_error_early", {31'd0, error_out}, 32'd0);
    tick();
`ifdef RSA_UNPACK_WATCHDOG_EN
    chk("wd_error", {31'd0, error_out}, 32'd1);
    chk("wd_collect", {31'd0, byte_ready_out}, 32'd1);
    tick();
    chk("wd_error_pulse", {31'd0, error_out}, 32'd0);
`else
    chk("hang_error", {31'd0, error_out}, 32'd0);
    for (int k = 0; k < 30; k++) tick();
    chk("hang_busy", {31'd0, busy_out}, 32'd1);
    chk("hang_not_ready", {31'd0, byte_ready_out}, 32'd0);
`endif
    chk("wd_count", {16'd0, block_count_out}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
